tile_plotter: RTL

Raster engine that sits directly upstream of the VGA adapter in the Monument Valley game datapath. On a start request it latches a rectangle (origin, width, height, 3-bit colour) and emits one pixel write per clock on the `plot`/`X`/`Y`/`color` bus. It drives the adapter's 320x240 frame buffer, so game logic can issue whole tile draws or erases instead of single pixels.

---
 rtl/tile_plotter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tile_plotter.sv
// Rectangle raster engine feeding the 320x240 VGA adapter, one pixel per clock.
// Optional build macro TILE_PLOTTER_CLIP_EN masks plot for off-screen pixels.
module tile_plotter #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [5:0] w,
  input  logic [5:0] h,
  input  logic [2:0] color_in,
  output logic       busy,
  output logic       done,
  output logic       plot,
  output logic [8:0] X,
  output logic [7:0] Y,
  output logic [2:0] color
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FIN
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] ox_q, ox_d;
  logic [7:0] oy_q, oy_d;
  logic [5:0] w_q, w_d;
  logic [5:0] h_q, h_d;
  logic [2:0] col_q, col_d;
  logic [5:0] cx_q, cx_d;
  logic [5:0] cy_q, cy_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       plot_q, plot_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] color_q, color_d;

  logic [9:0] xs;
  logic [8:0] ys;
  logic       pix_ok;
  logic       last_col;
  logic       last_row;

  assign xs       = {1'b0, ox_q} + {4'b0, cx_q};
  assign ys       = {1'b0, oy_q} + {3'b0, cy_q};
  assign last_col = (cx_q == w_q - 6'd1);
  assign last_row = (cy_q == h_q - 6'd1);

`ifdef TILE_PLOTTER_CLIP_EN
  assign pix_ok = (xs < 10'(SCREEN_W)) && (ys < 9'(SCREEN_H));
`else
  // Caller keeps the rectangle on screen; the wide sums are simply truncated.
  logic unused_clip;
  assign unused_clip = &{xs[9], ys[8],
                         (xs < 10'(SCREEN_W)), (ys < 9'(SCREEN_H))};
  assign pix_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        // The cycle that shows done still ignores start.
        if (start && !done_q) begin
          ox_d    = x0;
          oy_d    = y0;
          w_d     = w;
          h_d     = h;
          col_d   = color_in;
          cx_d    = 6'd0;
          cy_d    = 6'd0;
          busy_d  = 1'b1;
          if (w == 6'd0 || h == 6'd0) begin
            state_d = FIN;
          end else begin
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        busy_d  = 1'b1;
        plot_d  = pix_ok;
        x_d     = xs[8:0];
        y_d     = ys[7:0];
        color_d = col_q;
        if (last_col) begin
          cx_d = 6'd0;
          cy_d = cy_q + 6'd1;
          if (last_row) begin
            state_d = FIN;
          end
        end else begin
          cx_d = cx_q + 6'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign plot  = plot_q;
  assign X     = x_q;
  assign Y     = y_q;
  assign color = color_q;

endmodule
